conv_load_sequencer: RTL

CONV_LOAD_SEQUENCER -- requirements
Module: conv_load_sequencer

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_load_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution load sequencer.
package conv_pkg;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;
   localparam int SEL_W  = $clog2(DEPTH);
   localparam int LEN_W  = SEL_W + 1;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      PAD  = 2'd1,
      KICK = 2'd2,
      WAIT = 2'd3
   } seq_state_e;

   // A requested length of 0 or anything beyond the bank size means a full bank.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] fl);
      if (fl == '0 || fl > LEN_W'(DEPTH)) return LEN_W'(DEPTH);
      return fl;
   endfunction

endpackage

// File: rtl/conv_load_sequencer.sv
// Streams one frame of samples into a DEPTH-entry bank through an external demux,
// zero-pads the tail, kicks the convolution engine and waits for it to finish.
//
// state | meaning
// LOAD  | accepting upstream samples, writing them at idx
// PAD   | writing zeros from LEN up to the last bank entry
// KICK  | bank full; issue conv_start on the following cycle
// WAIT  | engine running; upstream stalled until conv_done
module conv_load_sequencer
   import conv_pkg::*;
#(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int DEPTH  = conv_pkg::DEPTH,
   parameter int SEL_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W:0]    frame_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] dmx_data,
   output logic [SEL_W-1:0]  dmx_sel,
   output logic              dmx_we,
   output logic              conv_start,
   input  logic              conv_done,
   output logic              busy,
   output logic [7:0]        frame_cnt
);

   seq_state_e        state_q, state_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [SEL_W:0]    len_q, len_d;
   logic              we_q, we_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              start_q, start_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [SEL_W:0]    cur_len;

   assign in_ready   = (state_q == LOAD);
   assign busy       = (state_q != LOAD);
   assign dmx_we     = we_q;
   assign dmx_sel    = sel_q;
   assign dmx_data   = data_q;
   assign conv_start = start_q;
   assign frame_cnt  = cnt_q;

   // Length is sampled only with the first sample so mid-frame changes are ignored.
   assign cur_len = (idx_q == '0) ? eff_len(frame_len) : len_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      we_d    = 1'b0;
      sel_d   = sel_q;
      data_d  = data_q;
      start_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               len_d  = cur_len;
               we_d   = 1'b1;
               sel_d  = idx_q;
               data_d = in_data;
               if ({1'b0, idx_q} == cur_len - (SEL_W+1)'(1)) begin
                  if (cur_len < (SEL_W+1)'(DEPTH)) begin
                     state_d = PAD;
                     idx_d   = idx_q + SEL_W'(1);
                  end else begin
                     state_d = KICK;
                  end
               end else begin
                  idx_d = idx_q + SEL_W'(1);
               end
            end
         end
         PAD: begin
            we_d   = 1'b1;
            sel_d  = idx_q;
            data_d = '0;
            if (idx_q == SEL_W'(DEPTH-1)) state_d = KICK;
            else                          idx_d   = idx_q + SEL_W'(1);
         end
         KICK: begin
            start_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (conv_done) begin
               state_d = LOAD;
               idx_d   = '0;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= '0;
         len_q   <= (SEL_W+1)'(DEPTH);
         we_q    <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
